nios2_sram_bridge: RTL and testbench

NIOS2_SRAM_BRIDGE -- requirements
Module: nios2_sram_bridge

---
 rtl/nios2_sram_bridge.sv | 130 +++++++++++++
 tb/tb_nios2_sram_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_sram_bridge.sv
// Avalon-MM register bridge that runs single 16-bit asynchronous SRAM accesses.
// Every SRAM pin is driven from a register, so reset can force them inactive at once.
module nios2_sram_bridge #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [19:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [19:0] addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] rdata_reg;
    logic [15:0] shadow_wdata;
    logic        shadow_rnw;
    logic [3:0]  count_reg;
    logic        done_reg;
    logic        err_reg;
    logic        dq_drive;

    logic reg_wr;
    logic ctrl_wr;
    logic unused_writedata;

    assign reg_wr           = chipselect & ~write_n;
    assign ctrl_wr          = reg_wr && (address == 2'd2);
    assign unused_writedata = ^writedata[31:20];

    // sram_addr doubles as the shadow address: it only changes when an access starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            shadow_wdata <= '0;
            shadow_rnw   <= 1'b0;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            dq_drive     <= 1'b0;
            sram_addr    <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_ub_n    <= 1'b1;
            sram_lb_n    <= 1'b1;
        end else begin
            if (reg_wr && (address == 2'd0)) addr_reg  <= writedata[19:0];
            if (reg_wr && (address == 2'd1)) wdata_reg <= writedata[15:0];

            // Sticky flags clear first; a start while busy then flags the overrun.
            if (ctrl_wr) begin
                done_reg <= 1'b0;
                err_reg  <= writedata[0] && (state != IDLE);
            end

            case (state)
                IDLE: begin
                    if (ctrl_wr && writedata[0]) begin
                        state        <= SETUP;
                        sram_addr    <= addr_reg;
                        shadow_wdata <= wdata_reg;
                        shadow_rnw   <= writedata[1];
                        count_reg    <= '0;
                        sram_ce_n    <= 1'b0;
                        sram_oe_n    <= ~writedata[1];
                        sram_ub_n    <= ~writedata[2];
                        sram_lb_n    <= ~writedata[3];
                        dq_drive     <= ~writedata[1];
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    count_reg <= '0;
                    sram_we_n <= shadow_rnw;
                end
                ACCESS: begin
                    if (count_reg == LAST_COUNT) begin
                        state     <= HOLD;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (shadow_rnw) rdata_reg <= sram_dq;
                    end else begin
                        count_reg <= count_reg + 4'd1;
                    end
                end
                HOLD: begin
                    state     <= IDLE;
                    sram_ce_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    dq_drive  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sram_dq = dq_drive ? shadow_wdata : 16'hzzzz;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = {12'd0, addr_reg};
            2'd1: readdata = {16'd0, wdata_reg};
            2'd2: readdata = {29'd0, err_reg, done_reg, state != IDLE};
            2'd3: readdata = {16'd0, rdata_reg};
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios2_sram_bridge.sv
// Directed bench for nios2_sram_bridge: register table plus hand-written access sequences
// against a small SRAM model that returns 0xA5C3 at word 0x00010 and 0x5A5A elsewhere.
module tb_nios2_sram_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd2;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    nios2_sram_bridge #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus while selected and output-enabled, logs write pulses.
    logic [15:0] model_rd;
    assign model_rd = (sram_addr == 20'h00010) ? 16'hA5C3 : 16'h5A5A;
    assign sram_dq  = (!sram_ce_n && !sram_oe_n) ? model_rd : 16'hzzzz;

    int          wr_cnt = 0;
    logic        prev_we = 1'b1;
    logic [19:0] last_addr = '0;
    logic [15:0] last_data = '0;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && prev_we) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= sram_addr;
            last_data <= sram_dq;
        end
        prev_we <= sram_we_n;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic dq_idle(input logic [15:0] v);
        return $isunknown(v) || (v == 16'h0000);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        address = a;
        #1;
        v = readdata;
        address = 2'd2;
    endtask

    // Six negedge samples starting in SETUP: SETUP, ACC, ACC, HOLD, IDLE, IDLE.
    logic [5:0]  we_p, oe_p, ce_p, ub_p, lb_p, busy_p, idle_p;
    logic [19:0] ad_s [6];
    logic [15:0] dq_s [6];

    task automatic trace();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we_p[i] = sram_we_n;  oe_p[i] = sram_oe_n;  ce_p[i] = sram_ce_n;
            ub_p[i] = sram_ub_n;  lb_p[i] = sram_lb_n;  busy_p[i] = readdata[0];
            idle_p[i] = dq_idle(sram_dq);
            ad_s[i] = sram_addr;  dq_s[i] = sram_dq;
        end
    endtask

    function automatic logic [3:0] addr_mask(input logic [19:0] exp);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (ad_s[i] == exp);
        return m;
    endfunction

    function automatic logic [3:0] dq_mask(input logic [15:0] exp);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (dq_s[i] === exp);
        return m;
    endfunction

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (readdata[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " reached idle"}, {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vt [8];
    logic [31:0] v;
    int          wr0;

    initial begin
        vt[0] = '{1'b0, 2'd0, 32'h0,        32'h0,        "ADDR reset"};
        vt[1] = '{1'b0, 2'd1, 32'h0,        32'h0,        "WDATA reset"};
        vt[2] = '{1'b0, 2'd2, 32'h0,        32'h0,        "STATUS reset"};
        vt[3] = '{1'b0, 2'd3, 32'h0,        32'h0,        "RDATA reset"};
        vt[4] = '{1'b1, 2'd0, 32'hFFFFFFFF, 32'h000FFFFF, "ADDR width"};
        vt[5] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0000FFFF, "WDATA width"};
        vt[6] = '{1'b1, 2'd3, 32'h00001234, 32'h0,        "RDATA read-only"};
        vt[7] = '{1'b1, 2'd2, 32'h00000000, 32'h0,        "CTRL no start"};

        repeat (3) @(posedge clk);
        #1;
        check("pins in reset", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) bus_write(vt[i].a, vt[i].d);
            read_reg(vt[i].a, v);
            check(vt[i].name, v, vt[i].exp);
        end

        // Plain write with both lanes.
        bus_write(2'd0, 32'h12345);
        bus_write(2'd1, 32'hBEEF);
        wr0 = wr_cnt;
        bus_write(2'd2, 32'h0D);
        trace();
        check("wr we_n", {26'd0, we_p}, 32'b111001);
        check("wr oe_n", {26'd0, oe_p}, 32'b111111);
        check("wr ce_n", {26'd0, ce_p}, 32'b110000);
        check("wr ub_n/lb_n", {20'd0, ub_p, lb_p}, {20'd0, 6'b110000, 6'b110000});
        check("wr busy", {26'd0, busy_p}, 32'b001111);
        check("wr sram_addr", {28'd0, addr_mask(20'h12345)}, 32'hF);
        check("wr sram_dq", {28'd0, dq_mask(16'hBEEF)}, 32'hF);
        check("wr dq released", {30'd0, idle_p[5:4]}, 32'b11);
        check("wr pulses", wr_cnt - wr0, 32'd1);
        check("wr data seen", {16'd0, last_data}, 32'hBEEF);
        read_reg(2'd2, v);
        check("wr status", v, 32'h2);

        // Read from the model's special word; WDATA non-zero so stray driving shows.
        bus_write(2'd1, 32'h3333);
        bus_write(2'd0, 32'h00010);
        bus_write(2'd2, 32'h0F);
        trace();
        check("rd oe_n", {26'd0, oe_p}, 32'b111000);
        check("rd we_n", {26'd0, we_p}, 32'b111111);
        check("rd busy", {26'd0, busy_p}, 32'b001111);
        check("rd dq not driven", {29'd0, idle_p[5:3]}, 32'b111);
        read_reg(2'd3, v);
        check("rd RDATA", v, 32'h0000A5C3);
        read_reg(2'd2, v);
        check("rd status", v, 32'h2);

        // Read with no byte lanes still captures.
        bus_write(2'd0, 32'h00020);
        bus_write(2'd2, 32'h03);
        trace();
        check("rd0 ub_n/lb_n", {20'd0, ub_p, lb_p}, {20'd0, 6'b111111, 6'b111111});
        check("rd0 ce_n", {26'd0, ce_p}, 32'b110000);
        read_reg(2'd3, v);
        check("rd0 RDATA", v, 32'h00005A5A);

        // Overrun: second start one cycle later is rejected.
        wr0 = wr_cnt;
        bus_write(2'd2, 32'h0D);
        bus_write(2'd2, 32'h0F);
        wait_idle("overrun");
        check("overrun pulses", wr_cnt - wr0, 32'd1);
        check("overrun data", {16'd0, last_data}, 32'h3333);
        read_reg(2'd2, v);
        check("overrun status", v, 32'h6);
        bus_write(2'd2, 32'h00);
        read_reg(2'd2, v);
        check("status cleared", v, 32'h0);

        // Shadowing: register updates mid-access must not leak to the SRAM.
        bus_write(2'd0, 32'h00100);
        bus_write(2'd1, 32'h1111);
        wr0 = wr_cnt;
        bus_write(2'd2, 32'h0D);
        bus_write(2'd0, 32'h00200);
        bus_write(2'd1, 32'h2222);
        wait_idle("shadow");
        check("shadow pulses", wr_cnt - wr0, 32'd1);
        check("shadow addr seen", {12'd0, last_addr}, 32'h00100);
        check("shadow data seen", {16'd0, last_data}, 32'h1111);
        read_reg(2'd0, v);
        check("ADDR readback", v, 32'h00200);
        read_reg(2'd1, v);
        check("WDATA readback", v, 32'h2222);

        // Lower lane only.
        bus_write(2'd2, 32'h09);
        trace();
        check("lb ub_n", {26'd0, ub_p}, 32'b111111);
        check("lb lb_n", {26'd0, lb_p}, 32'b110000);
        check("lb we_n", {26'd0, we_p}, 32'b111001);

        // Asynchronous reset in the middle of ACCESS.
        bus_write(2'd0, 32'h12345);
        bus_write(2'd1, 32'hBEEF);
        bus_write(2'd2, 32'h0D);
        @(posedge clk);
        #2;
        check("pre-reset we_n", {31'd0, sram_we_n}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("async pins", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("async dq released", {31'd0, dq_idle(sram_dq)}, 32'd1);
        check("async sram_addr", {12'd0, sram_addr}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_reg(vt[i].a, v);
            check({"post-reset ", vt[i].name}, v, vt[i].exp);
        end

        // First access after reset behaves normally.
        bus_write(2'd0, 32'h00055);
        bus_write(2'd1, 32'h00AA);
        wr0 = wr_cnt;
        bus_write(2'd2, 32'h0D);
        trace();
        check("post-reset we_n", {26'd0, we_p}, 32'b111001);
        check("post-reset busy", {26'd0, busy_p}, 32'b001111);
        check("post-reset pulses", wr_cnt - wr0, 32'd1);
        check("post-reset addr seen", {12'd0, last_addr}, 32'h00055);
        read_reg(2'd2, v);
        check("post-reset status", v, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule
